// File: rtl/lut_layer_seq_ctrl.sv
// Sequencer that time-multiplexes one shared truth-table LUT path across all
// neurons of a layer, one evaluation per cycle, and gathers the results.
module lut_layer_seq_ctrl #(
  parameter int IN_W    = 64,
  parameter int NEURONS = 100,
  parameter int IDX_W   = 7,
  parameter int LUT_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_vec,
  output logic [IN_W-1:0]    lat_vec,
  output logic               lut_issue,
  output logic [IDX_W-1:0]   lut_nidx,
  input  logic               lut_bit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NEURONS-1:0] out_vec,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOLD
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic [IDX_W-1:0]   nidx;
  logic               nidx_last;

  // Return pipe mirrors the LUT latency so each result lands on its own bit.
  logic [LUT_LAT-1:0] pipe_v;
  logic [IDX_W-1:0]   pipe_idx [LUT_LAT];
  logic               ret_valid;
  logic [IDX_W-1:0]   ret_idx;
  logic               drain_pending;

  assign nidx_last = (nidx == IDX_W'(NEURONS - 1));
  assign lut_nidx  = nidx;
  assign ret_valid = pipe_v[LUT_LAT-1];
  assign ret_idx   = pipe_idx[LUT_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = (state == IDLE) && !rst;
    accept     = 1'b0;
    lut_issue  = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        lut_issue = 1'b1;
        if (nidx_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!drain_pending) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Leave DRAIN on the edge that retires the last return: only the output
  // stage may still be valid, so the earlier stages must all be empty.
  always_comb begin
    drain_pending = 1'b0;
    for (int k = 0; k < LUT_LAT - 1; k++) begin
      drain_pending = drain_pending | pipe_v[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nidx <= '0;
    end else if (accept) begin
      nidx <= '0;
    end else if (state == ISSUE && !nidx_last) begin
      nidx <= nidx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_vec <= '0;
    end else if (accept) begin
      lat_vec <= in_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= lut_issue;
      for (int k = 1; k < LUT_LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
      end
    end
  end

  // NOTE: index entries are qualified by pipe_v, so they carry no reset.
  always_ff @(posedge clk) begin
    pipe_idx[0] <= nidx;
    for (int k = 1; k < LUT_LAT; k++) begin
      pipe_idx[k] <= pipe_idx[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vec <= '0;
    end else if (accept) begin
      out_vec <= '0;
    end else if (ret_valid) begin
      for (int i = 0; i < NEURONS; i++) begin
        if (ret_idx == IDX_W'(i)) begin
          out_vec[i] <= lut_bit;
        end
      end
    end
  end

endmodule

// File: tb/tb_lut_layer_seq_ctrl.sv
// Directed bench for lut_layer_seq_ctrl: three instances cover LUT_LAT=1,
// LUT_LAT=3 and a single-neuron layer, each with a small external LUT model.
module tb_lut_layer_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: IN_W=4, NEURONS=4, LUT_LAT=1
  logic       a_in_valid, a_in_ready, a_lut_issue, a_lut_bit;
  logic       a_out_valid, a_out_ready, a_busy;
  logic [3:0] a_in_vec, a_lat_vec, a_out_vec;
  logic [1:0] a_lut_nidx;

  // Instance B: IN_W=4, NEURONS=4, LUT_LAT=3
  logic       b_in_valid, b_in_ready, b_lut_issue, b_lut_bit;
  logic       b_out_valid, b_out_ready, b_busy, b_spur;
  logic [3:0] b_in_vec, b_lat_vec, b_out_vec;
  logic [1:0] b_lut_nidx;

  // Instance C: IN_W=4, NEURONS=1, LUT_LAT=1
  logic       c_in_valid, c_in_ready, c_lut_issue, c_lut_bit;
  logic       c_out_valid, c_out_ready, c_busy;
  logic [3:0] c_in_vec, c_lat_vec;
  logic [0:0] c_out_vec, c_lut_nidx;

  lut_layer_seq_ctrl #(.IN_W(4), .NEURONS(4), .IDX_W(2), .LUT_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_vec(a_in_vec), .lat_vec(a_lat_vec), .lut_issue(a_lut_issue),
    .lut_nidx(a_lut_nidx), .lut_bit(a_lut_bit), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_vec(a_out_vec), .busy(a_busy)
  );

  lut_layer_seq_ctrl #(.IN_W(4), .NEURONS(4), .IDX_W(2), .LUT_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_vec(b_in_vec), .lat_vec(b_lat_vec), .lut_issue(b_lut_issue),
    .lut_nidx(b_lut_nidx), .lut_bit(b_lut_bit), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_vec(b_out_vec), .busy(b_busy)
  );

  lut_layer_seq_ctrl #(.IN_W(4), .NEURONS(1), .IDX_W(1), .LUT_LAT(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_vec(c_in_vec), .lat_vec(c_lat_vec), .lut_issue(c_lut_issue),
    .lut_nidx(c_lut_nidx), .lut_bit(c_lut_bit), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_vec(c_out_vec), .busy(c_busy)
  );

  // External LUT models: result = lat_vec[nidx], delayed by the LUT latency.
  logic a_d1, b_d1, b_d2, b_d3, c_d1;
  always @(posedge clk) begin
    a_d1 <= a_lut_issue ? a_lat_vec[a_lut_nidx] : 1'b0;
    b_d1 <= b_lut_issue ? b_lat_vec[b_lut_nidx] : 1'b0;
    b_d2 <= b_d1;
    b_d3 <= b_d2;
    c_d1 <= c_lut_issue ? c_lat_vec[c_lut_nidx] : 1'b0;
  end
  assign a_lut_bit = a_d1;
  assign b_lut_bit = b_d3 | b_spur;
  assign c_lut_bit = c_d1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_vec = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_vec = '0; b_out_ready = 1'b0; b_spur = 1'b0;
    c_in_valid = 1'b0; c_in_vec = '0; c_out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({a_in_ready, a_busy, a_out_valid, a_lut_issue, a_lut_nidx, a_out_vec, a_lat_vec} !== 14'b0) begin
      errors++;
      $display("FAIL reset_a: got rdy=%b busy=%b ov=%b iss=%b nidx=%b out=%b lat=%b want all zero",
               a_in_ready, a_busy, a_out_valid, a_lut_issue, a_lut_nidx, a_out_vec, a_lat_vec);
    end
    checks++;
    if ({b_busy, b_out_valid, b_lut_issue, b_out_vec, c_busy, c_out_valid, c_out_vec} !== 10'b0) begin
      errors++;
      $display("FAIL reset_bc: got b_busy=%b b_ov=%b b_iss=%b b_out=%b c_busy=%b c_ov=%b c_out=%b want all zero",
               b_busy, b_out_valid, b_lut_issue, b_out_vec, c_busy, c_out_valid, c_out_vec);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({a_in_ready, b_in_ready, c_in_ready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 111", {a_in_ready, b_in_ready, c_in_ready});
    end
  endtask

  task automatic test_single;
    logic [4:0] exp;
    logic [4:0] got;
    a_out_ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      tick();
      a_in_valid = (c == 0);
      a_in_vec   = (c == 0) ? 4'b1011 : 4'b0000;
      #1;
      exp = {(c == 0 || c >= 7), (c >= 1 && c <= 6), (c == 6), (c >= 1 && c <= 4),
             (c >= 1 && c <= 4) ? 2'(c - 1) : 2'b00};
      got = {a_in_ready, a_busy, a_out_valid, a_lut_issue, a_lut_issue ? a_lut_nidx : 2'b00};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_ctrl cycle %0d: got rdy/busy/ov/iss/nidx=%b want %b", c, got, exp);
      end
      if (c == 6) begin
        checks++;
        if (a_out_vec !== 4'b1011) begin
          errors++;
          $display("FAIL single_out_vec: got %b want 1011", a_out_vec);
        end
      end
    end
  endtask

  task automatic test_hold;
    a_out_ready = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      tick();
      a_in_valid  = (c == 0);
      a_in_vec    = (c == 0) ? 4'b1011 : 4'b0000;
      a_out_ready = (c == 11);
      #1;
      if (c == 5) begin
        checks++;
        if (a_out_valid !== 1'b0) begin
          errors++;
          $display("FAIL hold_early_valid: got %b want 0", a_out_valid);
        end
      end
      if (c >= 6 && c <= 11) begin
        checks++;
        if ({a_out_valid, a_busy, a_in_ready, a_out_vec, a_lat_vec} !== 11'b110_1011_1011) begin
          errors++;
          $display("FAIL hold_stable cycle %0d: got ov=%b busy=%b rdy=%b out=%b lat=%b want 1 1 0 1011 1011",
                   c, a_out_valid, a_busy, a_in_ready, a_out_vec, a_lat_vec);
        end
      end
      if (c == 12) begin
        checks++;
        if ({a_busy, a_in_ready, a_out_valid} !== 3'b010) begin
          errors++;
          $display("FAIL hold_release: got busy/rdy/ov=%b want 010", {a_busy, a_in_ready, a_out_valid});
        end
      end
    end
    a_out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [2:0] exp;
    a_out_ready = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      tick();
      a_in_valid = (c <= 7);
      a_in_vec   = (c == 0) ? 4'b1011 : (c <= 7) ? 4'b0110 : 4'b1111;
      #1;
      exp = {(c == 0 || c == 7 || c == 14), ((c >= 1 && c <= 6) || (c >= 8 && c <= 13)),
             (c == 6 || c == 13)};
      checks++;
      if ({a_in_ready, a_busy, a_out_valid} !== exp) begin
        errors++;
        $display("FAIL b2b_ctrl cycle %0d: got rdy/busy/ov=%b want %b", c, {a_in_ready, a_busy, a_out_valid}, exp);
      end
      if ((c == 3 || c == 6) && a_lat_vec !== 4'b1011) begin
        errors++;
        $display("FAIL b2b_lat_first cycle %0d: got %b want 1011", c, a_lat_vec);
      end
      if (c == 3 || c == 6) checks++;
      if ((c == 10 || c == 13) && a_lat_vec !== 4'b0110) begin
        errors++;
        $display("FAIL b2b_lat_second cycle %0d: got %b want 0110", c, a_lat_vec);
      end
      if (c == 10 || c == 13) checks++;
      if (c == 6) begin
        checks++;
        if (a_out_vec !== 4'b1011) begin
          errors++;
          $display("FAIL b2b_out_first: got %b want 1011", a_out_vec);
        end
      end
      if (c == 13) begin
        checks++;
        if (a_out_vec !== 4'b0110) begin
          errors++;
          $display("FAIL b2b_out_second: got %b want 0110", a_out_vec);
        end
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_latency3;
    logic [4:0] exp;
    logic [4:0] got;
    b_out_ready = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      tick();
      b_in_valid = (c == 0);
      b_in_vec   = (c == 0) ? 4'b0100 : 4'b0000;
      b_spur     = (c >= 1 && c <= 3);
      #1;
      exp = {(c == 0 || c == 9), (c >= 1 && c <= 8), (c == 8), (c >= 1 && c <= 4),
             (c >= 1 && c <= 4) ? 2'(c - 1) : 2'b00};
      got = {b_in_ready, b_busy, b_out_valid, b_lut_issue, b_lut_issue ? b_lut_nidx : 2'b00};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL lat3_ctrl cycle %0d: got rdy/busy/ov/iss/nidx=%b want %b", c, got, exp);
      end
      if (c == 4) begin
        checks++;
        if (b_out_vec !== 4'b0000) begin
          errors++;
          $display("FAIL lat3_spurious: got %b want 0000", b_out_vec);
        end
      end
      if (c == 8) begin
        checks++;
        if (b_out_vec !== 4'b0100) begin
          errors++;
          $display("FAIL lat3_out_vec: got %b want 0100", b_out_vec);
        end
      end
    end
    b_in_valid = 1'b0;
    b_spur     = 1'b0;
  endtask

  task automatic test_reset_mid;
    a_out_ready = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      tick();
      a_in_valid = (c == 0);
      a_in_vec   = (c == 0) ? 4'b1111 : 4'b0000;
      rst        = (c == 3);
      #1;
      if (c == 3) begin
        checks++;
        if ({a_in_ready, a_out_vec} !== 5'b0_0001) begin
          errors++;
          $display("FAIL rstmid_pre: got rdy=%b out=%b want 0 0001", a_in_ready, a_out_vec);
        end
      end
      if (c == 4) begin
        checks++;
        if ({a_busy, a_lut_issue, a_out_valid, a_in_ready, a_out_vec, a_lat_vec, a_lut_nidx} !== 14'b0001_0000_0000_00) begin
          errors++;
          $display("FAIL rstmid_after: got busy=%b iss=%b ov=%b rdy=%b out=%b lat=%b nidx=%b want 0 0 0 1 0000 0000 00",
                   a_busy, a_lut_issue, a_out_valid, a_in_ready, a_out_vec, a_lat_vec, a_lut_nidx);
        end
      end
      if (c == 5) begin
        checks++;
        if ({a_busy, a_out_vec} !== 5'b0_0000) begin
          errors++;
          $display("FAIL rstmid_late_return: got busy=%b out=%b want 0 0000", a_busy, a_out_vec);
        end
      end
    end
    for (int c = 0; c <= 7; c++) begin
      tick();
      a_in_valid = (c == 0);
      a_in_vec   = (c == 0) ? 4'b0101 : 4'b0000;
      #1;
      if (c == 6) begin
        checks++;
        if ({a_out_valid, a_out_vec} !== 5'b1_0101) begin
          errors++;
          $display("FAIL rstmid_fresh: got ov=%b out=%b want 1 0101", a_out_valid, a_out_vec);
        end
      end
      if (c == 7) begin
        checks++;
        if ({a_in_ready, a_busy} !== 2'b10) begin
          errors++;
          $display("FAIL rstmid_fresh_idle: got rdy/busy=%b want 10", {a_in_ready, a_busy});
        end
      end
    end
  endtask

  task automatic test_single_neuron;
    logic [3:0] vecs [2];
    logic       exp_bit [2];
    logic [3:0] exp;
    vecs[0] = 4'b0001; exp_bit[0] = 1'b1;
    vecs[1] = 4'b1110; exp_bit[1] = 1'b0;
    c_out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      for (int c = 0; c <= 4; c++) begin
        tick();
        c_in_valid = (c == 0);
        c_in_vec   = (c == 0) ? vecs[t] : 4'b0000;
        #1;
        exp = {(c == 0 || c == 4), (c >= 1 && c <= 3), (c == 3), (c == 1)};
        checks++;
        if ({c_in_ready, c_busy, c_out_valid, c_lut_issue} !== exp) begin
          errors++;
          $display("FAIL n1_ctrl vec %0d cycle %0d: got rdy/busy/ov/iss=%b want %b",
                   t, c, {c_in_ready, c_busy, c_out_valid, c_lut_issue}, exp);
        end
        if (c == 1) begin
          checks++;
          if (c_lut_nidx !== 1'b0) begin
            errors++;
            $display("FAIL n1_nidx vec %0d: got %b want 0", t, c_lut_nidx);
          end
        end
        if (c == 3) begin
          checks++;
          if (c_out_vec[0] !== exp_bit[t]) begin
            errors++;
            $display("FAIL n1_out_vec vec %0d: got %b want %b", t, c_out_vec[0], exp_bit[t]);
          end
        end
      end
    end
    c_in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_back_to_back();
    test_latency3();
    test_reset_mid();
    test_single_neuron();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lut_layer_seq_ctrl.md
Name: lut_layer_seq_ctrl

Overview:
Sequencer that time-multiplexes one shared truth-table LUT path across all neurons of a LogicNets layer. It accepts one layer input vector per transaction and issues one neuron evaluation per cycle to the shared LUT path, which has a fixed latency. It collects the 1-bit neuron results into an output vector and presents that vector downstream with a valid/ready handshake. It sits between two layer register stages. The fan-in gather network and the per-neuron truth tables (6-bit address, 1-bit result) are external.

Parameters:
IN_W, 64, width of the layer input vector.
NEURONS, 100, number of neurons in the layer; must be >= 1.
IDX_W, 7, neuron index width; must satisfy 2**IDX_W >= NEURONS.
LUT_LAT, 1, fixed cycles from lut_issue to lut_bit; must be >= 1.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  controller can accept an input vector
in_vec  in  IN_W  layer input vector
lat_vec  out  IN_W  latched input, drives the external fan-in gather network
lut_issue  out  1  evaluation request this cycle
lut_nidx  out  IDX_W  neuron index of the current request
lut_bit  in  1  neuron result, valid LUT_LAT cycles after the matching lut_issue
out_valid  out  1  out_vec is complete
out_ready  in  1  downstream accepts out_vec
out_vec  out  NEURONS  neuron results; bit i = neuron i
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE; lat_vec=0; out_vec=0; lut_issue=0; lut_nidx=0; out_valid=0; busy=0; return-pipe valids=0.
- in_ready = (state==IDLE) && !rst, combinational.
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
- IDLE: when in_valid && in_ready:
  - lat_vec<=in_vec; out_vec<=0; nidx<=0; next state ISSUE.
  - Otherwise hold state.
- ISSUE: lut_issue=1 and lut_nidx=nidx every cycle.
  - If nidx==NEURONS-1, go to DRAIN.
  - Otherwise nidx<=nidx+1. nidx never wraps.
- Return pipe: a LUT_LAT-deep shift register of {valid, idx}, loaded from {lut_issue, lut_nidx}.
  - When the pipe output is valid, out_vec[idx]<=lut_bit at that edge.
  - lut_bit is ignored whenever the pipe output is invalid.
- DRAIN: wait until the pipe holds no valid entry, then go to HOLD. DRAIN lasts exactly LUT_LAT cycles.
- HOLD: out_valid=1; out_vec and lat_vec are stable.
  - On out_ready, go to IDLE.
  - out_valid stays high until that handshake.
- Timing, with the accept in cycle 0:
  - Issues occur in cycles 1..NEURONS.
  - out_valid rises in cycle NEURONS+LUT_LAT+1.
  - With out_ready held at 1, the next accept is possible in cycle NEURONS+LUT_LAT+2, giving a period of NEURONS+LUT_LAT+2.
- in_valid while state != IDLE: not accepted, no effect.
- NEURONS==1: ISSUE lasts one cycle.
- Reset during any state: abort the transaction and apply the reset values above. In-flight returns are discarded, and a lut_bit arriving after reset must not modify out_vec.
- lut_nidx holds its last value when lut_issue=0; consumers must qualify it with lut_issue.

Test Plan:
1. IN_W=4, NEURONS=4, LUT_LAT=1; bench LUT model lut_bit=lat_vec[nidx] delayed 1 cycle; accept in_vec=4'b1011 in cycle 0 -> lut_issue high in cycles 1-4 with lut_nidx 0,1,2,3; out_valid rises in cycle 6 with out_vec=4'b1011.
2. Same setup, out_ready held 0 for 5 cycles after out_valid -> out_vec stays 4'b1011, in_ready=0 and busy=1 throughout; handshake in the 6th cycle -> IDLE on the next cycle.
3. Back-to-back vectors 4'b1011 then 4'b0110 with in_valid and out_ready held 1 -> accepts in cycles 0 and 7; outputs 1011 then 0110; in_vec changes while busy do not alter lat_vec.
4. LUT_LAT=3 -> out_valid rises in cycle 8; a spurious lut_bit=1 driven in cycles 1-3 (no return pending) leaves out_vec bits unaffected.
5. Assert rst in cycle 3 (mid-ISSUE) -> the next cycle shows state IDLE, out_vec=0, lut_issue=0; the late return does not set any out_vec bit; a fresh transaction completes correctly.
6. NEURONS=1, LUT_LAT=1 -> single issue in cycle 1 with lut_nidx=0; out_valid in cycle 3.
